echo_detector: RTL and testbench

ECHO_DETECTOR -- requirements
Module: echo_detector

---
 rtl/echo_detector_pkg.sv | 18 +
 rtl/echo_peak_tracker.sv | 32 +++
 rtl/echo_detector.sv | 150 +++++++++++++++
 tb/tb_echo_detector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/echo_detector_pkg.sv
// Echo detector shared types and defaults.
// State encoding plus default tuning constants.
package echo_detector_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SEARCH,
    S_PULSE
  } state_t;

  localparam int DEF_THRESH    = 32;
  localparam int DEF_BLANK     = 4;
  localparam int DEF_MIN_WIDTH = 2;
  localparam int DEF_MAX_CNT   = 4095;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/echo_peak_tracker.sv
// Tracks the largest sample of an echo and its timestamp.
// Ties keep the earliest timestamp.
module echo_peak_tracker
  import echo_detector_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [7:0]       sample,
  input  logic [CNT_W-1:0] t,
  output logic [7:0]       peak_amp,
  output logic [CNT_W-1:0] peak_time
);

  // clear loads the first sample; later strictly larger samples replace it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_amp  <= '0;
      peak_time <= '0;
    end else if (clear) begin
      peak_amp  <= sample;
      peak_time <= t;
    end else if (en && (sample > peak_amp)) begin
      peak_amp  <= sample;
      peak_time <= t;
    end
  end

endmodule

// File: rtl/echo_detector.sv
// Echo detector: blanks leakage, finds first wide echo,
// reports its peak and midpoint, or times out.
module echo_detector
  import echo_detector_pkg::*;
#(
  parameter int THRESH    = DEF_THRESH,
  parameter int BLANK     = DEF_BLANK,
  parameter int MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int MAX_CNT   = DEF_MAX_CNT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       signal,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] peak_time,
  output logic [CNT_W-1:0] mid_time,
  output logic [7:0]       peak_amp
);

  localparam logic [7:0]       THR   = 8'(THRESH);
  localparam logic [CNT_W-1:0] BL_M1 = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] W_MIN = CNT_W'(MIN_WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rise_q, fall_q, width_q;
  logic [CNT_W:0]   mid_sum;
  logic             above, at_max, wide, last_blank;
  logic             done, tout, trk_clear, trk_en;
  logic [7:0]       trk_amp;
  logic [CNT_W-1:0] trk_time;

  assign above      = signal >= THR;
  assign at_max     = cnt_q == T_MAX;
  assign wide       = width_q >= W_MIN;
  assign last_blank = cnt_q == BL_M1;
  assign busy       = state_q != S_IDLE;
  assign mid_sum    = {1'b0, rise_q} + {1'b0, fall_q};

  echo_peak_tracker #(.CNT_W(CNT_W)) u_peak (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (trk_clear),
    .en        (trk_en),
    .sample    (signal),
    .t         (cnt_q),
    .peak_amp  (trk_amp),
    .peak_time (trk_time)
  );

  // Next state; echo end beats the MAX_CNT timeout on the same sample
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    tout      = 1'b0;
    trk_clear = 1'b0;
    trk_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (BLANK == 0) ? S_SEARCH : S_BLANK;
      end
      S_BLANK: begin
        if (at_max) begin
          tout    = 1'b1;
          state_d = S_IDLE;
        end else if (last_blank) begin
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (at_max) begin
          tout    = 1'b1;
          state_d = S_IDLE;
        end else if (above) begin
          trk_clear = 1'b1;
          state_d   = S_PULSE;
        end
      end
      S_PULSE: begin
        if (above) begin
          trk_en = 1'b1;
          if (at_max) begin
            tout    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (wide) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (at_max) begin
          tout    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_SEARCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timestamp counter and one-cycle strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      valid   <= done;
      timeout <= tout;
      if (state_q == S_IDLE) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;
    end
  end

  // Rise/fall edges and saturating width of the open pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q  <= '0;
      fall_q  <= '0;
      width_q <= '0;
    end else if (trk_clear) begin
      rise_q  <= cnt_q;
      fall_q  <= cnt_q;
      width_q <= CNT_W'(1);
    end else if (trk_en) begin
      fall_q <= cnt_q;
      if (width_q != '1) width_q <= width_q + 1'b1;
    end
  end

  // Result registers hold until the next accepted echo
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_time <= '0;
      mid_time  <= '0;
      peak_amp  <= '0;
    end else if (done) begin
      peak_time <= trk_time;
      mid_time  <= mid_sum[CNT_W:1];
      peak_amp  <= trk_amp;
    end
  end

endmodule

// File: tb/tb_echo_detector.sv
// Scoreboard bench for echo_detector.
// Two instances: default MAX_CNT and MAX_CNT=15.
module tb_echo_detector;

  typedef struct {
    int          cyc;
    bit          is_to;
    logic [15:0] pt;
    logic [15:0] mt;
    logic [7:0]  pa;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start0, start1;
  logic [7:0]  sig0, sig1;
  logic        busy0, valid0, timeout0;
  logic        busy1, valid1, timeout1;
  logic [15:0] pt0, mt0, pt1, mt1;
  logic [7:0]  pa0, pa1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   prof[0:4199];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  echo_detector u_d0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .signal(sig0),
    .busy(busy0), .valid(valid0), .timeout(timeout0),
    .peak_time(pt0), .mid_time(mt0), .peak_amp(pa0)
  );

  echo_detector #(.MAX_CNT(15)) u_d1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .signal(sig1),
    .busy(busy1), .valid(valid1), .timeout(timeout1),
    .peak_time(pt1), .mid_time(mt1), .peak_amp(pa1)
  );

  task automatic check_strobe(input int id, input logic v, input logic to,
                              input logic b, input logic [15:0] pt,
                              input logic [15:0] mt, input logic [7:0] pa);
    exp_t e;
    bit   empty;
    n_cmp++;
    empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_bad++;
      $display("FAIL strobe%0d: got v=%0b to=%0b at cyc %0d, required no strobe",
               id, v, to, cyc);
      return;
    end
    e = (id == 0) ? q0.pop_front() : q1.pop_front();
    if ((v && to) || (v != !e.is_to) || (to != e.is_to) || b ||
        (cyc != e.cyc) || (pt != e.pt) || (mt != e.mt) || (pa != e.pa)) begin
      n_bad++;
      $display("FAIL strobe%0d: got v=%0b to=%0b busy=%0b cyc=%0d pt=%0d mt=%0d pa=%0d, required to=%0b busy=0 cyc=%0d pt=%0d mt=%0d pa=%0d",
               id, v, to, b, cyc, pt, mt, pa,
               e.is_to, e.cyc, e.pt, e.mt, e.pa);
    end
  endtask

  always @(negedge clk)
    if (valid0 || timeout0)
      check_strobe(0, valid0, timeout0, busy0, pt0, mt0, pa0);

  always @(negedge clk)
    if (valid1 || timeout1)
      check_strobe(1, valid1, timeout1, busy1, pt1, mt1, pa1);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_prof;
    for (int i = 0; i < 4200; i++) prof[i] = 0;
  endtask

  task automatic run(input int id, input int n, input bit push,
                     input bit is_to, input int end_t, input int pt,
                     input int mt, input int pa, input int dup_t);
    exp_t e;
    if (id == 0) start0 = 1'b1;
    else         start1 = 1'b1;
    tick;
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_after_start", 32'((id == 0) ? busy0 : busy1), 32'd1);
    if (push) begin
      e.cyc   = cyc + end_t + 1;
      e.is_to = is_to;
      e.pt    = 16'(pt);
      e.mt    = 16'(mt);
      e.pa    = 8'(pa);
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
    for (int t = 0; t < n; t++) begin
      if (id == 0) sig0 = 8'(prof[t]);
      else         sig1 = 8'(prof[t]);
      if (t == dup_t) begin
        if (id == 0) start0 = 1'b1;
        else         start1 = 1'b1;
      end
      tick;
      start0 = 1'b0;
      start1 = 1'b0;
    end
    sig0 = '0;
    sig1 = '0;
    tick;
    tick;
  endtask

  task automatic set_basic;
    clr_prof;
    prof[10] = 5;  prof[11] = 48; prof[12] = 99;
    prof[13] = 48; prof[14] = 5;
  endtask

  initial begin
    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    sig0    = '0;
    sig1    = '0;
    clr_prof;
    tick;
    tick;
    chk("reset_d0", 32'(busy0 | valid0 | timeout0 | (|pt0) | (|mt0) | (|pa0)), 32'd0);
    chk("reset_d1", 32'(busy1 | valid1 | timeout1 | (|pt1) | (|mt1) | (|pa1)), 32'd0);
    reset_n = 1'b1;
    tick;

    // basic echo: rise 11, fall 13, peak 99 at 12
    set_basic;
    run(0, 18, 1'b1, 1'b0, 14, 12, 12, 99, -1);

    // blanked 200 at t2, then silence: timeout at t4095, results held
    clr_prof;
    prof[2] = 200;
    run(0, 4098, 1'b1, 1'b1, 4095, 12, 12, 99, -1);

    // t3 blanked, echo starts exactly at t4
    clr_prof;
    prof[3] = 200; prof[4] = 70; prof[5] = 60;
    run(0, 9, 1'b1, 1'b0, 6, 4, 4, 70, -1);

    // narrow pulse rejected, then 40,90,40 at t30-32
    clr_prof;
    prof[20] = 80;
    prof[30] = 40; prof[31] = 90; prof[32] = 40;
    run(0, 36, 1'b1, 1'b0, 33, 31, 31, 90, -1);

    // tie on the peak keeps earliest
    clr_prof;
    prof[50] = 60; prof[51] = 90; prof[52] = 90; prof[53] = 60;
    run(0, 57, 1'b1, 1'b0, 54, 51, 51, 90, -1);

    // d1 (MAX_CNT=15): plain echo 100,100 at t5-6
    clr_prof;
    prof[5] = 100; prof[6] = 100;
    run(1, 10, 1'b1, 1'b0, 7, 5, 5, 100, -1);

    // d1: pulse open at MAX_CNT -> timeout; start during busy ignored
    clr_prof;
    prof[12] = 50; prof[13] = 50; prof[14] = 50; prof[15] = 50;
    run(1, 17, 1'b1, 1'b1, 15, 5, 5, 100, 5);

    // d1: echo ends on the MAX_CNT sample -> valid wins
    clr_prof;
    prof[13] = 40; prof[14] = 40;
    run(1, 17, 1'b1, 1'b0, 15, 13, 13, 40, -1);

    // abort mid-pulse with reset, no strobe expected
    set_basic;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int t = 0; t < 13; t++) begin
      sig0 = 8'(prof[t]);
      tick;
    end
    sig0 = '0;
    reset_n = 1'b0;
    #1;
    chk("abort_clear", 32'(busy0 | valid0 | timeout0 | (|pt0) | (|mt0) | (|pa0)), 32'd0);
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    run(0, 18, 1'b1, 1'b0, 14, 12, 12, 99, -1);

    tick;
    tick;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
